// File: rtl/pulse_stretcher_pkg.sv
// Shared constants and state encoding for the pulse stretcher.
package pulse_stretcher_pkg;

    localparam int CNT_W  = 8;
    localparam int PEND_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Strobe/clear inputs and pulse/status outputs of the pulse stretcher.
interface pulse_stretcher_if;

    logic                                   STB;
    logic                                   CLR;
    logic                                   O;
    logic                                   BUSY;
    logic [pulse_stretcher_pkg::PEND_W-1:0] PEND;
    logic                                   OVF;

    modport master (output STB, CLR, input  O, BUSY, PEND, OVF);
    modport slave  (input  STB, CLR, output O, BUSY, PEND, OVF);

endinterface

// File: rtl/pulse_stretcher_pend_counter.sv
// Saturating up/down counter for pending events; ovf pulses when an
// increment is refused because the count already sits at max.
module pend_counter
    import pulse_stretcher_pkg::*;
#(
    parameter int W = PEND_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         ovf
);

    assign ovf = inc && !dec && (count == max);

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (inc && !dec && count != max) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle strobes into HIGH_LEN-high / GAP_LEN-low pulses.
// Define PULSE_STRETCHER_QUEUE_EN to queue strobes that arrive while busy.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH_LEN = 8,
    parameter int GAP_LEN  = 2,
    parameter int PEND_MAX = 8
) (
    input  logic               CLK,
    input  logic               RST,
    pulse_stretcher_if.slave   bus
);

    localparam logic [CNT_W-1:0]  HIGH_LOAD  = CNT_W'(HIGH_LEN - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_LEN - 1);
    localparam logic [PEND_W-1:0] PEND_LIMIT = PEND_W'(PEND_MAX);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               o_q, busy_q, ovf_q;
    logic               o_next, busy_next, ovf_next;
    logic               start, event_req, ovf_set;
    logic               inc, dec, drop;
    logic [PEND_W-1:0]  pend;
    logic               pend_any;

    assign pend_any  = (pend != '0);
    assign event_req = bus.STB || pend_any;

`ifdef PULSE_STRETCHER_QUEUE_EN
    // A strobe that starts a pulse while events wait is enqueued behind them,
    // and the oldest waiting event is the one consumed.
    assign dec     = start && pend_any;
    assign inc     = bus.STB && !(start && !pend_any);
    assign ovf_set = drop;
`else
    // Without a queue the counter idles at zero; any strobe not taken is lost.
    assign dec     = 1'b0;
    assign inc     = 1'b0;
    assign ovf_set = drop || (bus.STB && !start);
`endif

    pend_counter #(.W(PEND_W)) u_pend (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (inc),
        .dec   (dec),
        .max   (PEND_LIMIT),
        .count (pend),
        .ovf   (drop)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            o_q    <= 1'b0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            o_q    <= o_next;
            busy_q <= busy_next;
            ovf_q  <= ovf_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_next = state;
        cnt_next   = cnt;
        start      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (event_req) begin
                    start      = 1'b1;
                    state_next = ST_HIGH;
                    cnt_next   = HIGH_LOAD;
                end
            end
            ST_HIGH: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    state_next = ST_GAP;
                    cnt_next   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (event_req) begin
                    start      = 1'b1;
                    state_next = ST_HIGH;
                    cnt_next   = HIGH_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        o_next    = (state_next == ST_HIGH);
        busy_next = (state_next != ST_IDLE);
        ovf_next  = ovf_q;
        if (ovf_set) begin
            ovf_next = 1'b1;
        end else if (bus.CLR) begin
            ovf_next = 1'b0;
        end
    end

    assign bus.O    = o_q;
    assign bus.BUSY = busy_q;
    assign bus.PEND = pend;
    assign bus.OVF  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed scenarios with hand-computed checkpoints; a negedge monitor pops
// and compares them. Queue scenarios run when PULSE_STRETCHER_QUEUE_EN is set.
module tb_pulse_stretcher;
    import pulse_stretcher_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    pulse_stretcher_if bus ();

    pulse_stretcher #(
        .HIGH_LEN (4),
        .GAP_LEN  (2),
        .PEND_MAX (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int                scen;
        int                e;
        logic              o;
        logic              busy;
        logic [PEND_W-1:0] pend;
        logic              ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_item;
    int   cur_scen;
    int   edge_no;
    int   n_cmp;
    int   n_bad;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic exp_at(input int e, input logic o, input logic busy,
                          input logic [PEND_W-1:0] pend, input logic ovf);
        exp_t x;
        x.scen = cur_scen;
        x.e    = e;
        x.o    = o;
        x.busy = busy;
        x.pend = pend;
        x.ovf  = ovf;
        exp_q.push_back(x);
    endtask

    function automatic bit [63:0] span(input int lo, input int hi);
        bit [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].scen == cur_scen && exp_q[0].e < edge_no) begin
            mon_item = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL s%0d_e%0d: got no sample at edge %0d, required one", mon_item.scen,
                     mon_item.e, mon_item.e);
        end
        if (exp_q.size() > 0 && exp_q[0].scen == cur_scen && exp_q[0].e == edge_no) begin
            mon_item = exp_q.pop_front();
            check($sformatf("s%0d_e%0d {O,BUSY,PEND,OVF}", mon_item.scen, mon_item.e),
                  32'({bus.O, bus.BUSY, bus.PEND, bus.OVF}),
                  32'({mon_item.o, mon_item.busy, mon_item.pend, mon_item.ovf}));
        end
    end

    task automatic begin_scen(input int id);
        cur_scen = id;
        edge_no  = 0;
        bus.STB  = 1'b0;
        bus.CLR  = 1'b0;
        RST      = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1 RST = 1'b0;
    endtask

    // Edge e sees stb_m[e]/clr_m[e]; rst_e pulses RST asynchronously mid-cycle
    // and releases it before that edge.
    task automatic run(input bit [63:0] stb_m, input bit [63:0] clr_m,
                       input int rst_e, input int n);
        for (int e = 1; e <= n; e++) begin
            @(negedge CLK);
            #2;
            bus.STB = stb_m[e];
            bus.CLR = clr_m[e];
            if (e == rst_e) begin
                RST = 1'b1;
                #2 RST = 1'b0;
            end
            @(posedge CLK);
            edge_no = e;
        end
        @(negedge CLK);
        #1;
        bus.STB = 1'b0;
        bus.CLR = 1'b0;
        while (exp_q.size() > 0) begin
            mon_item = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL s%0d_e%0d: got no sample within %0d edges, required one",
                     mon_item.scen, mon_item.e, n);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        cur_scen = 0;
        edge_no  = 0;
        RST      = 1'b1;
        bus.STB  = 1'b0;
        bus.CLR  = 1'b0;

        // Single strobe: 4 high, 2 low, then idle.
        begin_scen(1);
        exp_at(9,  0, 0, 0, 0);
        exp_at(10, 1, 1, 0, 0);
        exp_at(13, 1, 1, 0, 0);
        exp_at(14, 0, 1, 0, 0);
        exp_at(15, 0, 1, 0, 0);
        exp_at(16, 0, 0, 0, 0);
        run(span(10, 10), '0, 0, 20);

        // Strobe exactly at the end of GAP with nothing pending: no idle cycle.
        begin_scen(2);
        exp_at(15, 0, 1, 0, 0);
        exp_at(16, 1, 1, 0, 0);
        exp_at(19, 1, 1, 0, 0);
        exp_at(20, 0, 1, 0, 0);
        exp_at(21, 0, 1, 0, 0);
        exp_at(22, 0, 0, 0, 0);
        run(span(10, 10) | span(16, 16), '0, 0, 24);

`ifdef PULSE_STRETCHER_QUEUE_EN
        // Three strobes back to back replay with period 6.
        begin_scen(3);
        exp_at(10, 1, 1, 0, 0);
        exp_at(11, 1, 1, 1, 0);
        exp_at(12, 1, 1, 2, 0);
        exp_at(15, 0, 1, 2, 0);
        exp_at(16, 1, 1, 1, 0);
        exp_at(21, 0, 1, 1, 0);
        exp_at(22, 1, 1, 0, 0);
        exp_at(25, 1, 1, 0, 0);
        exp_at(26, 0, 1, 0, 0);
        exp_at(27, 0, 1, 0, 0);
        exp_at(28, 0, 0, 0, 0);
        run(span(10, 12), '0, 0, 30);

        // Saturation: drops at 13 and 14; CLR at 13 loses to the drop, CLR at 20 clears.
        begin_scen(4);
        exp_at(12, 1, 1, 2, 0);
        exp_at(13, 1, 1, 2, 1);
        exp_at(14, 0, 1, 2, 1);
        exp_at(16, 1, 1, 1, 1);
        exp_at(19, 1, 1, 1, 1);
        exp_at(20, 0, 1, 1, 0);
        exp_at(22, 1, 1, 0, 0);
        exp_at(28, 0, 0, 0, 0);
        run(span(10, 14), span(13, 13) | span(20, 20), 0, 30);

        // Strobe at GAP end while one event waits: enqueue and consume, PEND stays 1.
        begin_scen(5);
        exp_at(11, 1, 1, 1, 0);
        exp_at(15, 0, 1, 1, 0);
        exp_at(16, 1, 1, 1, 0);
        exp_at(21, 0, 1, 1, 0);
        exp_at(22, 1, 1, 0, 0);
        exp_at(27, 0, 1, 0, 0);
        exp_at(28, 0, 0, 0, 0);
        run(span(10, 11) | span(16, 16), '0, 0, 30);

        // Async reset mid-HIGH with PEND=2 and OVF=1, then a fresh full pulse.
        begin_scen(6);
        exp_at(12, 1, 1, 2, 0);
        exp_at(13, 1, 1, 2, 1);
        exp_at(14, 0, 0, 0, 0);
        exp_at(15, 0, 0, 0, 0);
        exp_at(16, 1, 1, 0, 0);
        exp_at(19, 1, 1, 0, 0);
        exp_at(20, 0, 1, 0, 0);
        exp_at(22, 0, 0, 0, 0);
        run(span(10, 13) | span(16, 16), '0, 14, 24);
`else
        // No queue: strobe during HIGH is dropped; CLR with a drop keeps OVF set.
        begin_scen(3);
        exp_at(10, 1, 1, 0, 0);
        exp_at(11, 1, 1, 0, 0);
        exp_at(12, 1, 1, 0, 1);
        exp_at(13, 1, 1, 0, 1);
        exp_at(14, 0, 1, 0, 1);
        exp_at(16, 0, 0, 0, 1);
        exp_at(18, 0, 0, 0, 0);
        run(span(10, 10) | span(12, 12), span(12, 12) | span(18, 18), 0, 20);

        // Async reset mid-HIGH with OVF=1, then a fresh full pulse.
        begin_scen(4);
        exp_at(12, 1, 1, 0, 1);
        exp_at(13, 1, 1, 0, 1);
        exp_at(14, 0, 0, 0, 0);
        exp_at(15, 0, 0, 0, 0);
        exp_at(16, 1, 1, 0, 0);
        exp_at(19, 1, 1, 0, 0);
        exp_at(20, 0, 1, 0, 0);
        exp_at(22, 0, 0, 0, 0);
        run(span(10, 10) | span(12, 12) | span(16, 16), '0, 14, 24);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_O",    32'(bus.O),    32'd0);
        check("final_BUSY", 32'(bus.BUSY), 32'd0);
        check("final_PEND", 32'(bus.PEND), 32'd0);
        check("final_OVF",  32'(bus.OVF),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle event strobes, such as the one-cycle pulses produced by the input debouncers, into output pulses of guaranteed minimum high and low length, for example for LEDs or slow peripherals in the blinking-point designs. Strobes that arrive while a pulse is in progress can be queued and replayed back-to-back, so no event is lost silently. Overflow is reported through a sticky flag.

## Interface
- HIGH_LEN, 8: output high time in CLK cycles; legal range 1..255.
- GAP_LEN, 2: minimum low time after each pulse in CLK cycles; legal range 1..255.
- PEND_MAX, 8: queue depth for pending events; legal range 1..15.
- RST  in  1  reset, asynchronous, active-high.
- CLK  in  1  clock; all logic is on the rising edge.
- STB  in  1  event strobe, sampled every edge; each high cycle is one event.
- CLR  in  1  clears OVF.
- O    out 1  stretched pulse output, registered.
- BUSY out 1  high when state is not IDLE, registered.
- PEND out 4  number of pending events, registered.
- OVF  out 1  sticky flag: at least one event was dropped.

## Operation
- States: IDLE, HIGH, GAP. Down counter CNT is 8 bits wide.
- Start condition, evaluated at each edge:
  - in IDLE: STB=1 or PEND>0;
  - in GAP: CNT==0 and (STB=1 or PEND>0).
- On a start: go to HIGH, O<=1, CNT<=HIGH_LEN-1.
- HIGH, CNT!=0: CNT decrements. HIGH, CNT==0: go to GAP, O<=0, CNT<=GAP_LEN-1.
- GAP, CNT!=0: CNT decrements. GAP, CNT==0 with no start: go to IDLE.
- Queue bookkeeping at each edge:
  - inc = STB=1 and the event does not cause the start at this edge;
  - dec = start taken from the queue (PEND>0 and STB=0), or start caused by STB while PEND>0. In that case STB is enqueued and the oldest event is consumed.
  - Net effect: PEND += inc - dec.
  - An inc with PEND==PEND_MAX and no dec drops the event: PEND stays, OVF<=1.
- CLR=1 sets OVF<=0. If a drop happens at the same edge, the set wins.
- Reset clears everything at once: state IDLE, CNT=0, O=0, BUSY=0, PEND=0, OVF=0. A pulse in progress is truncated.

## Timing
- Latency from STB to O: STB high at edge k in IDLE gives O=1 after edge k.
- O stays high for exactly HIGH_LEN cycles, then low for at least GAP_LEN cycles.
- Queued events repeat with period HIGH_LEN+GAP_LEN, with no IDLE cycle in between.
- BUSY falls after the edge that ends GAP with no start pending.
- O is never high for fewer than HIGH_LEN cycles, except when cut short by RST.

## Configuration
- PULSE_STRETCHER_QUEUE_EN defined: the queue behaves as described above.
- PULSE_STRETCHER_QUEUE_EN undefined:
  - no queue; STB is accepted only when it meets a start condition;
  - any STB outside a start condition is dropped and sets OVF;
  - PEND is tied to 0 and PEND_MAX is ignored.

## Structure
- Package pulse_stretcher_pkg holds:
  - the state encoding constants ST_IDLE=0, ST_HIGH=1, ST_GAP=2;
  - the CNT width (8) and PEND width (4) constants.
- Sub-module pend_counter: a saturating up/down counter with inc, dec and max inputs and an overflow-pulse output. The FSM, CNT and OVF stay in the top level.

## Test plan
All scenarios use HIGH_LEN=4, GAP_LEN=2 and PEND_MAX=2 unless stated otherwise.
1. Single STB at edge 10:
   - O=1 after edges 10–13, O=0 after edge 14;
   - BUSY=0 after edge 16; PEND stays 0.
2. Queue enabled, STB at edges 10, 11 and 12:
   - PEND reads 1 then 2;
   - O rises after edges 10, 16 and 22;
   - PEND reads 1 after edge 16 and 0 after edge 22.
3. Queue enabled, STB at edges 10–14:
   - PEND saturates at 2 and OVF=1 after edge 13;
   - CLR at edge 20 gives OVF=0; the two queued pulses are still emitted.
4. Boundary case, PEND=1 and STB at edge 16 (GAP end):
   - HIGH restarts at edge 16 and PEND stays 1.
   - Separately, with PEND=0 and STB at edge 16: restart, PEND stays 0, no IDLE cycle.
5. RST asserted mid-HIGH, with PEND=2 and OVF=1:
   - O, BUSY, PEND and OVF all read 0 immediately;
   - the first STB after release gives a full 4-cycle pulse.
6. Macro undefined, STB at edges 10 and 12:
   - a single 4-cycle pulse is emitted;
   - OVF=1 after edge 12 and PEND stays 0.
